// File: rtl/audio_dac_serializer.sv
// Mono-to-stereo left-justified serializer: sample FIFO, bclk divider, 64-slot frame.
// Optional saturating underrun counter port enabled by defining UNDERRUN_CNT_EN.
module audio_dac_serializer #(
    parameter int unsigned BCLK_DIV   = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        bclk,
    output logic        lrck,
    output logic        sdata,
    output logic        underrun
`ifdef UNDERRUN_CNT_EN
    ,
    output logic [15:0] underrun_count
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL    = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0]  DIV_MAX = 8'(BCLK_DIV - 1);

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [7:0]    div_cnt;
    logic [5:0]    slot;
    logic [5:0]    slot_nxt;
    logic [31:0]   frame;
    logic [31:0]   head;
    logic          fifo_empty;
    logic          fall;
    logic          frame_start;
    logic          push;
    logic          pop;

    assign fifo_empty   = (count == '0);
    assign sample_ready = (count != FULL);
    assign push         = sample_valid && sample_ready;
    assign fall         = bclk && (div_cnt == DIV_MAX);
    assign frame_start  = fall && (slot == '1);
    // Pop decision uses the pre-push count, so a push into an empty FIFO on a frame start is kept.
    assign pop          = frame_start && !fifo_empty;
    assign slot_nxt     = slot + 6'd1;
    assign head         = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            div_cnt  <= '0;
            slot     <= '1;
            frame    <= '0;
            bclk     <= 1'b0;
            lrck     <= 1'b1;
            sdata    <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end

            underrun <= 1'b0;
            if (div_cnt == DIV_MAX) begin
                div_cnt <= '0;
                bclk    <= ~bclk;
                if (bclk) begin
                    slot <= slot_nxt;
                    lrck <= slot_nxt[5];
                    if (frame_start) begin
                        frame    <= fifo_empty ? 32'd0 : head;
                        sdata    <= fifo_empty ? 1'b0 : head[31];
                        underrun <= fifo_empty;
                    end else begin
                        // Bit 31-k for slot k in either half equals ~k[4:0].
                        sdata <= frame[~slot_nxt[4:0]];
                    end
                end
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
        end
    end

`ifdef UNDERRUN_CNT_EN
    logic [15:0] und_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            und_cnt <= '0;
        end else if (frame_start && fifo_empty && (und_cnt != '1)) begin
            und_cnt <= und_cnt + 16'd1;
        end
    end

    assign underrun_count = und_cnt;
`endif

endmodule
